irrigation_request: RTL and testbench
=====================================

IRRIGATION_REQUEST -- requirements
Module: irrigation_request

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, meaning the stable cycles a key level must hold before acceptance (20 ms at 50 MHz).
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 50000000, meaning the minimum idle gap in cycles between accepted requests (1 s).
REQ-003 SHALL have port CLOCK_50, input, 1 bit, the single 50 MHz clock; all logic on rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port key_n, input, 3 bits, raw active-low buttons: [2] dawn, [1] dusk, [0] control; asynchronous to CLOCK_50.
REQ-006 SHALL have port req_valid, output, 1 bit, request offered to the irrigation controller.
REQ-007 SHALL have port req_code, output, 2 bits: 01 dawn (3 s run), 10 dusk (6 s run), 11 control (start/cancel), 00 none.
REQ-008 SHALL have port req_ack, input, 1 bit, controller accepts the offered request.
REQ-009 SHALL have port pend_led, output, 1 bit, high while any request is pending or offered.

Function
REQ-010 SHALL pass each key_n bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL change a key's debounced level only after DEB_CYCLES consecutive cycles of a synchronized level differing from the current debounced level; any reversion restarts the count from 0.
REQ-012 SHALL generate a one-cycle press event on a debounced 1->0 transition only; releases produce no event.
REQ-013 SHALL latch each press event into a per-key pending flag; repeated presses while pending coalesce into one.
REQ-014 SHALL implement FSM IDLE -> OFFER -> HOLDOFF -> IDLE.
REQ-015 SHALL, in IDLE with any flag set, enter OFFER on the next edge with req_valid=1 and req_code chosen by priority control > dawn > dusk.
REQ-016 SHALL hold req_valid and req_code stable in OFFER until a transfer (req_valid && req_ack at a rising edge); req_ack outside OFFER is ignored.
REQ-017 SHALL, on transfer, clear only the offered flag, drop req_valid, set req_code=00 and enter HOLDOFF.
REQ-018 SHALL re-set the flag if a press event of the offered key coincides with its transfer (set wins).
REQ-019 SHALL stay in HOLDOFF exactly HOLDOFF_CYCLES cycles, then return to IDLE, while still latching press events.
REQ-020 SHALL drive pend_led = OR of pending flags OR req_valid.
REQ-021 SHALL NOT let a lower-priority press arriving during OFFER preempt the offered code.

Reset
REQ-022 SHALL, while RESET_N=0, force FSM=IDLE, req_valid=0, req_code=00, pend_led=0, flags=0, counters=0, and synchronizer and debounced levels=1 (released).
REQ-023 SHALL not emit a press event for a key held low through reset deassertion until it has debounced (DEB_CYCLES stable cycles after sync).
REQ-024 SHALL, on reset mid-OFFER, drop req_valid asynchronously and discard the offer.

Configuration
REQ-025 SHALL, with JARDIM_HOLDOFF_EN defined, implement HOLDOFF per REQ-019.
REQ-026 SHALL, without JARDIM_HOLDOFF_EN, go directly from transfer to IDLE, so the next offer can appear 1 cycle after transfer; HOLDOFF_CYCLES is then unused.

Structure
REQ-027 SHALL place REQ_NONE/REQ_DAWN/REQ_DUSK/REQ_CTRL codes and FSM state encoding in shared package jardim_pkg.
REQ-028 SHALL implement per-key sync+debounce+edge detection as sub-module key_debounce, instantiated 3 times.

Verification (DEB_CYCLES=4, HOLDOFF_CYCLES=8)
REQ-029 SHALL cover: key_n[2] low for 3 cycles then high -> no event, req_valid stays 0.
REQ-030 SHALL cover: key_n[2] held low -> req_valid=1, req_code=01 after sync+4 stable cycles+1; req_ack pulse -> req_valid=0 next edge.
REQ-031 SHALL cover: dawn and dusk pressed in the same cycle -> offer 01; after 8 holdoff cycles offer 10.
REQ-032 SHALL cover: req_ack held 0 for 20 cycles while control pressed -> req_code stays 01 until ack; then control (11) is offered.
REQ-033 SHALL cover: RESET_N=0 during OFFER -> req_valid=0 immediately, pend_led=0; keys released -> nothing offered.
REQ-034 SHALL cover: with JARDIM_HOLDOFF_EN undefined, two pending flags -> second offer 1 cycle after first transfer.

Source files
------------

// File: rtl/jardim_pkg.sv
// Shared request codes, FSM state encoding and arbitration helpers for the
// irrigation request front end.
package jardim_pkg;

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_DAWN = 2'b01;
  localparam logic [1:0] REQ_DUSK = 2'b10;
  localparam logic [1:0] REQ_CTRL = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StOffer   = 2'b01,
    StHoldoff = 2'b10
  } req_state_e;

  // Flag bit order follows key_n: [2] dawn, [1] dusk, [0] control.
  function automatic logic [1:0] pick_code(input logic [2:0] flags);
    if (flags[0]) begin
      return REQ_CTRL;
    end else if (flags[2]) begin
      return REQ_DAWN;
    end else if (flags[1]) begin
      return REQ_DUSK;
    end
    return REQ_NONE;
  endfunction

  function automatic logic [2:0] code_mask(input logic [1:0] code);
    case (code)
      REQ_CTRL: return 3'b001;
      REQ_DAWN: return 3'b100;
      REQ_DUSK: return 3'b010;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, stable-count debouncer and a
// one-cycle press pulse on the debounced release-to-press transition.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized level matches the debounced one restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = deb_q & ~deb_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/irrigation_request.sv
// Turns three debounced buttons into prioritized valid/ack requests for the
// irrigation controller. Define JARDIM_HOLDOFF_EN to enforce an idle gap after each transfer.
module irrigation_request
  import jardim_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 1000000,
  parameter int unsigned HOLDOFF_CYCLES = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [2:0] key_n,
  output logic       req_valid,
  output logic [1:0] req_code,
  input  logic       req_ack,
  output logic       pend_led
);

  if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
    $error("HOLDOFF_CYCLES must be at least 1");
  end

  logic [2:0] press;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_key (
      .clk_i  (CLOCK_50),
      .rst_ni (RESET_N),
      .key_ni (key_n[i]),
      .press_o(press[i])
    );
  end

  req_state_e state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [2:0] flags_q, flags_d;
  logic [2:0] clr;

`ifdef JARDIM_HOLDOFF_EN
  localparam int unsigned HoldW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLDOFF_CYCLES - 1);
  logic [HoldW-1:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    clr     = 3'b000;
`ifdef JARDIM_HOLDOFF_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      StIdle: begin
        if (|flags_q) begin
          state_d = StOffer;
          code_d  = pick_code(flags_q);
        end
      end
      StOffer: begin
        if (req_ack) begin
          clr    = code_mask(code_q);
          code_d = REQ_NONE;
`ifdef JARDIM_HOLDOFF_EN
          state_d = StHoldoff;
          hold_d  = '0;
`else
          state_d = StIdle;
`endif
        end
      end
      StHoldoff: begin
`ifdef JARDIM_HOLDOFF_EN
        if (hold_q == HoldMax) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
    // A press landing on its own transfer re-arms the flag.
    flags_d = (flags_q & ~clr) | press;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      code_q  <= REQ_NONE;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      flags_q <= flags_d;
    end
  end

`ifdef JARDIM_HOLDOFF_EN
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign req_valid = (state_q == StOffer);
  assign req_code  = code_q;
  assign pend_led  = (|flags_q) | req_valid;

endmodule

// File: tb/tb_irrigation_request.sv
// Self-checking bench for irrigation_request: directed scenarios with literal
// expectations plus randomized buttons/ack compared every cycle against a behavioural model.
module tb_irrigation_request;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
`ifdef JARDIM_HOLDOFF_EN
  localparam int GapExp = 2 + HOLD;
`else
  localparam int GapExp = 2;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [2:0] key_n    = 3'b111;
  logic       req_ack  = 1'b0;
  logic       req_valid;
  logic [1:0] req_code;
  logic       pend_led;

  int n_checks = 0;
  int n_fail   = 0;

  irrigation_request #(
    .DEB_CYCLES    (DEB),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .key_n    (key_n),
    .req_valid(req_valid),
    .req_code (req_code),
    .req_ack  (req_ack),
    .pend_led (pend_led)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 offering, 2 holdoff countdown.
  typedef struct packed {
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       lvl;
    logic [2:0]       pend;
    logic [2:0][31:0] run;
    int               phase;
    logic [1:0]       code;
    int               left;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.s1 = 3'b111;
    r.s2 = 3'b111;
    r.lvl = 3'b111;
    return r;
  endfunction

  function automatic model_t model_next(input model_t c, input logic [2:0] kn, input logic ack);
    model_t     n;
    logic [2:0] ev;
    n  = c;
    ev = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (c.s2[k] != c.lvl[k]) begin
        n.run[k] = c.run[k] + 1;
        if (n.run[k] == DEB) begin
          n.lvl[k] = c.s2[k];
          n.run[k] = 0;
          ev[k]    = !c.s2[k];
        end
      end else begin
        n.run[k] = 0;
      end
    end
    n.s1 = kn;
    n.s2 = c.s1;
    if (c.phase == 0) begin
      if (c.pend[0]) begin
        n.phase = 1; n.code = 2'b11;
      end else if (c.pend[2]) begin
        n.phase = 1; n.code = 2'b01;
      end else if (c.pend[1]) begin
        n.phase = 1; n.code = 2'b10;
      end
    end else if (c.phase == 1) begin
      if (ack) begin
        if (c.code == 2'b11) n.pend[0] = 1'b0;
        if (c.code == 2'b01) n.pend[2] = 1'b0;
        if (c.code == 2'b10) n.pend[1] = 1'b0;
        n.code = 2'b00;
`ifdef JARDIM_HOLDOFF_EN
        n.phase = 2;
        n.left  = HOLD;
`else
        n.phase = 0;
`endif
      end
    end else begin
      n.left = c.left - 1;
      if (n.left == 0) n.phase = 0;
    end
    n.pend = n.pend | ev;
    return n;
  endfunction

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) m <= model_reset();
    else          m <= model_next(m, key_n, req_ack);
  end

  always @(negedge CLOCK_50) begin
    check("model req_valid", int'(req_valid), int'(m.phase == 1));
    check("model req_code", int'(req_code), int'(m.code));
    check("model pend_led", int'(pend_led), int'((|m.pend) || (m.phase == 1)));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!req_valid && n < 60);
    if (!req_valid) check({name, " timeout"}, int'(req_valid), 1);
  endtask

  // Pulse ack for one cycle, then measure negedges until the next offer.
  task automatic ack_and_gap(input string name, output int gap);
    req_ack = 1'b1;
    @(negedge CLOCK_50);
    req_ack = 1'b0;
    check({name, " drop"}, int'(req_valid), 0);
    gap = 1;
    while (!req_valid && gap < 60) begin
      @(negedge CLOCK_50);
      gap++;
    end
  endtask

  int n;
  int hl[3];

  initial begin
    idle(3);
    check("reset req_valid", int'(req_valid), 0);
    check("reset req_code", int'(req_code), 0);
    check("reset pend_led", int'(pend_led), 0);
    RESET_N = 1'b1;
    idle(2);

    // Bounce shorter than the debounce window.
    key_n[2] = 1'b0;
    idle(3);
    key_n[2] = 1'b1;
    idle(12);
    check("bounce no valid", int'(req_valid), 0);
    check("bounce no led", int'(pend_led), 0);

    // Single dawn press: 2 sync + 4 stable + 1 to offer.
    key_n[2] = 1'b0;
    wait_valid("dawn", n);
    check("dawn latency", n, 7);
    check("dawn code", int'(req_code), 1);
    key_n = 3'b111;
    req_ack = 1'b1;
    @(negedge CLOCK_50);
    req_ack = 1'b0;
    check("dawn ack drop", int'(req_valid), 0);
    check("dawn ack led", int'(pend_led), 0);
    idle(15);

    // Dawn and dusk together: dawn first, dusk after the gap.
    key_n = 3'b001;
    wait_valid("dawn+dusk", n);
    check("dawn+dusk first code", int'(req_code), 1);
    key_n = 3'b111;
    ack_and_gap("dawn+dusk", n);
    check("dawn+dusk gap", n, GapExp);
    check("dawn+dusk second code", int'(req_code), 2);
    req_ack = 1'b1;
    @(negedge CLOCK_50);
    req_ack = 1'b0;
    idle(15);

    // Control pressed while dawn is offered and not acked.
    key_n[2] = 1'b0;
    wait_valid("ctrl hold", n);
    key_n = 3'b110;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      check("dawn held code", int'(req_code), 1);
    end
    check("ctrl pending led", int'(pend_led), 1);
    key_n = 3'b111;
    ack_and_gap("ctrl", n);
    check("ctrl gap", n, GapExp);
    check("ctrl code", int'(req_code), 3);
    req_ack = 1'b1;
    @(negedge CLOCK_50);
    req_ack = 1'b0;
    idle(15);

    // Reset in the middle of an offer.
    key_n[1] = 1'b0;
    wait_valid("dusk reset", n);
    check("dusk code", int'(req_code), 2);
    key_n = 3'b111;
    #2 RESET_N = 1'b0;
    #1;
    check("async reset valid", int'(req_valid), 0);
    check("async reset led", int'(pend_led), 0);
    check("async reset code", int'(req_code), 0);
    idle(3);
    RESET_N = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK_50);
      check("post reset quiet", int'(req_valid), 0);
    end

    // Key held low through reset release still has to debounce.
    key_n[2] = 1'b0;
    idle(2);
    RESET_N = 1'b0;
    idle(2);
    RESET_N = 1'b1;
    wait_valid("held reset", n);
    check("held through reset latency", n, 7);
    key_n = 3'b111;
    req_ack = 1'b1;
    @(negedge CLOCK_50);
    req_ack = 1'b0;
    idle(15);

    // Randomized buttons and ack; the model compare process does the checking.
    for (int k = 0; k < 3; k++) hl[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLOCK_50);
      for (int k = 0; k < 3; k++) begin
        if (hl[k] == 0) begin
          key_n[k] = 1'($urandom_range(0, 1));
          hl[k] = $urandom_range(1, 12);
        end else begin
          hl[k]--;
        end
      end
      req_ack = ($urandom_range(0, 3) == 0);
    end
    key_n = 3'b111;
    req_ack = 1'b1;
    idle(60);
    req_ack = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
